// File: rtl/uart_pkg.sv
// Shared UART framing definitions used by both uart_rx and uart_tx.
// Frame: one start bit, UART_DATA_BITS data bits LSB first, one stop bit, no parity.
package uart_pkg;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; 2-cycle latency, no backpressure.
// Both flops reset to 1 so an idle line never looks like a start edge out of reset.
module uart_rx_sync (
  input  logic clk_16x,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_16x or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, bit centre found by counting BAUD_TICK_COUNT clk_16x cycles per bit; no backpressure,
// rx_valid/rx_frame_err pulse one cycle after the stop sample. UART_RX_MAJORITY_EN adds 2-of-3 bit voting.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_TICK_COUNT = 16
) (
  input  logic                      clk_16x,
  input  logic                      rst_n,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  output logic                      rx_busy,
  output logic                      rx_frame_err
);

  localparam int CW = $clog2(BAUD_TICK_COUNT);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] HALF_TICK = CW'(BAUD_TICK_COUNT / 2 - 1);
  localparam logic [CW-1:0] LAST_TICK = CW'(BAUD_TICK_COUNT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(UART_DATA_BITS - 1);

  logic rx_s;
  logic line;
  logic line_prev;
  logic bit_val;

  uart_rx_sync u_sync (
    .clk_16x (clk_16x),
    .rst_n   (rst_n),
    .d       (rx),
    .q       (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // The FSM runs one cycle behind rx_s so the sample after the centre is already available.
  logic [1:0] hist;

  always_ff @(posedge clk_16x or negedge rst_n) begin
    if (!rst_n) hist <= 2'b11;
    else        hist <= {hist[0], rx_s};
  end

  assign line    = hist[0];
  assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign line    = rx_s;
  assign bit_val = rx_s;
`endif

  uart_state_t               state, state_nxt;
  logic [CW-1:0]             cnt, cnt_nxt;
  logic [BW-1:0]             bit_idx, bit_idx_nxt;
  logic [UART_DATA_BITS-1:0] shreg, shreg_nxt;
  logic [UART_DATA_BITS-1:0] data_nxt;
  logic                      valid_nxt;
  logic                      ferr_nxt;

  always_ff @(posedge clk_16x or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      line_prev    <= 1'b1;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      bit_idx      <= bit_idx_nxt;
      shreg        <= shreg_nxt;
      rx_data      <= data_nxt;
      rx_valid     <= valid_nxt;
      rx_frame_err <= ferr_nxt;
      line_prev    <= line;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = (cnt == LAST_TICK) ? '0 : cnt + 1'b1;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    data_nxt    = rx_data;
    valid_nxt   = 1'b0;
    ferr_nxt    = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        // Edge-triggered, so a line stuck low after a break cannot retrigger.
        if (line_prev && !line) state_nxt = START;
      end
      START: begin
        if (cnt == HALF_TICK) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          state_nxt   = (bit_val == UART_START_BIT) ? DATA : IDLE;
        end
      end
      DATA: begin
        if (cnt == LAST_TICK) begin
          shreg_nxt = {bit_val, shreg[UART_DATA_BITS-1:1]};
          if (bit_idx == LAST_BIT) state_nxt = STOP;
          else                     bit_idx_nxt = bit_idx + 1'b1;
        end
      end
      STOP: begin
        if (cnt == LAST_TICK) begin
          state_nxt = IDLE;
          if (bit_val == UART_STOP_BIT) begin
            data_nxt  = shreg;
            valid_nxt = 1'b1;
          end else begin
            ferr_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rx_busy = (state != IDLE);

endmodule
